// File: rtl/log2_sched_pkg.sv
// ============================================================================
// Module      : log2_sched_pkg
// Description : Shared state encoding and counter width for log2_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package log2_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DONE_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/log2_sched_rr_arb.sv
// ============================================================================
// Module      : rr_arb
// Description : Combinational round-robin arbiter, search starts after 'last'.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb
    import log2_sched_pkg::*;
#(
    parameter int R = 4,
    localparam int IW = $clog2(R)
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [R-1:0]  grant
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= R; k++) begin
            idx = IW'((int'(last) + k) % R);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/log2_sched.sv
// ============================================================================
// Module      : log2_sched
// Description : Round-robin scheduled, bit-serial floor(log2) unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module log2_sched
    import log2_sched_pkg::*;
#(
    parameter int N = 8,
    parameter int R = 4,
    localparam int M  = $clog2(N),
    localparam int IW = $clog2(R)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [R-1:0]          req_valid,
    input  logic [R*N-1:0]        req_value,
    output logic [R-1:0]          req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IW-1:0]         rsp_id,
    output logic [M-1:0]          rsp_result,
    output logic                  rsp_exact,
    output logic                  rsp_zero,
    output logic                  busy,
    output logic [DONE_CNT_W-1:0] done_cnt
);

    localparam logic [M-1:0] CNT_INIT = M'(N - 1);

    state_t                state_q, state_d;
    logic [IW-1:0]         last_q, last_d;
    logic [N-1:0]          sh_q, sh_d;
    logic [M-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]         id_q, id_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]         rsp_id_q, rsp_id_d;
    logic [M-1:0]          rsp_result_q, rsp_result_d;
    logic                  rsp_exact_q, rsp_exact_d;
    logic                  rsp_zero_q, rsp_zero_d;
    logic [DONE_CNT_W-1:0] done_cnt_q, done_cnt_d;

    logic [R-1:0]  grant;
    logic [IW-1:0] win_idx;
    logic [N-1:0]  win_val;
    logic          accept;

    rr_arb #(.R(R)) u_arb (
        .req   (req_valid),
        .last  (last_q),
        .grant (grant)
    );

    // Grants are only offered in IDLE and never while reset is being applied.
    assign req_ready = (reset_n && state_q == IDLE) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        win_idx = '0;
        win_val = '0;
        for (int i = 0; i < R; i++) begin
            if (grant[i]) begin
                win_idx = IW'(i);
                win_val = req_value[i*N +: N];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_exact_d  = rsp_exact_q;
        rsp_zero_d   = rsp_zero_q;
        done_cnt_d   = done_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d    = win_val;
                    cnt_d   = CNT_INIT;
                    id_d    = win_idx;
                    last_d  = win_idx;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Normalise left until the MSB is set; cnt tracks its bit position.
                if (sh_q[N-1]) begin
                    rsp_result_d = cnt_q;
                    rsp_exact_d  = (sh_q[N-2:0] == '0);
                    rsp_zero_d   = 1'b0;
                    rsp_id_d     = id_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else if (cnt_q == '0) begin
                    rsp_result_d = '0;
                    rsp_exact_d  = 1'b0;
                    rsp_zero_d   = 1'b1;
                    rsp_id_d     = id_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    sh_d  = sh_q << 1;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_q       <= IW'(R - 1);
            sh_q         <= '0;
            cnt_q        <= '0;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_exact_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_exact_q  <= rsp_exact_d;
            rsp_zero_q   <= rsp_zero_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_exact  = rsp_exact_q;
    assign rsp_zero   = rsp_zero_q;
    assign busy       = (state_q != IDLE);
    assign done_cnt   = done_cnt_q;

endmodule

`default_nettype wire

// File: doc/log2_sched.md
LOG2_SCHED -- requirements
Module: log2_sched

Interface
REQ-001 SHALL have parameter N, default 8: width of each operand.
REQ-002 SHALL have parameter R, default 4: number of requesters (R >= 2).
REQ-003 SHALL have localparams M = $clog2(N) (result width) and IW = $clog2(R) (requester ID width).
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port req_valid, input, R: per-requester operand valid.
REQ-007 SHALL have port req_value, input, R*N: operands; requester i occupies bits [i*N +: N].
REQ-008 SHALL have port req_ready, output, R: one-hot grant; accept of requester i = req_valid[i] & req_ready[i].
REQ-009 SHALL have port rsp_valid, output, 1: response valid.
REQ-010 SHALL have port rsp_ready, input, 1: response consumer ready.
REQ-011 SHALL have port rsp_id, output, IW: requester index of the response.
REQ-012 SHALL have port rsp_result, output, M: floor(log2(operand)); 0 when operand is 0.
REQ-013 SHALL have port rsp_exact, output, 1: operand is a nonzero power of two.
REQ-014 SHALL have port rsp_zero, output, 1: operand was 0 (log undefined).
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-016 SHALL have port done_cnt, output, 16: count of completed response handshakes; wraps at 16'hFFFF -> 0.

Function
REQ-017 SHALL implement FSM states IDLE, CALC, RESP.
REQ-018 In IDLE, SHALL assert req_ready only for the round-robin winner among asserted req_valid; req_ready SHALL be all-zero in CALC and RESP.
REQ-019 Round-robin SHALL search from (last_grant+1) mod R upward; last_grant SHALL update to the winner on acceptance only.
REQ-020 On acceptance, SHALL load sh <= operand, cnt <= N-1, id <= winner, and go to CALC.
REQ-021 In CALC, each cycle: if sh[N-1]=1, result <= cnt, exact <= (sh[N-2:0]==0), zero <= 0, go RESP.
REQ-022 In CALC, if sh[N-1]=0 and cnt=0: result <= 0, exact <= 0, zero <= 1, go RESP.
REQ-023 In CALC otherwise: sh <= sh<<1, cnt <= cnt-1, stay.
REQ-024 Latency from acceptance edge to rsp_valid high SHALL be (N-1-floor(log2 v))+1 cycles, N cycles for v=0 (v=1: 8, v=0x80: 1 at N=8).
REQ-025 In RESP, rsp_valid SHALL be 1 and rsp_id/result/exact/zero SHALL stay stable until rsp_ready is sampled high.
REQ-026 On rsp_valid & rsp_ready: go IDLE, increment done_cnt; no new acceptance in that same cycle (one-cycle bubble).
REQ-027 Outputs rsp_* SHALL be registered; req_ready SHALL be combinational from state, req_valid and last_grant.
REQ-028 Requesters deasserting req_valid while not granted SHALL be allowed; no request is queued internally.

Reset
REQ-029 While reset_n=0 at a clock edge: state <= IDLE, last_grant <= R-1 (requester 0 wins first), done_cnt <= 0, rsp_valid <= 0, rsp_id/result/exact/zero <= 0.
REQ-030 Reset mid-CALC or mid-RESP SHALL abandon the operation; no response is produced and done_cnt is not incremented.
REQ-031 req_ready SHALL be 0 during the reset cycle.

Structure
REQ-032 Package log2_sched_pkg SHALL hold the state enum type (IDLE, CALC, RESP) and the done_cnt width constant.
REQ-033 The round-robin arbiter SHALL be the sub-module rr_arb (parameter R; inputs req, last; output one-hot grant).
REQ-034 The shift/count datapath SHALL remain in log2_sched.

Verification (N=8, R=4)
REQ-035 Reset, then req_valid=4'b0001 with value0=8'h40 -> req_ready=0001; 2 cycles later rsp_valid=1, id=0, result=6, exact=1, zero=0.
REQ-036 value=8'h01 -> rsp after 8 cycles, result=0, exact=1; value=8'h00 -> after 8 cycles, result=0, zero=1, exact=0; value=8'hFF -> after 1 cycle, result=7, exact=0.
REQ-037 All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; done_cnt increments once per response.
REQ-038 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, req_ready=0000, busy=1; release -> single handshake, then IDLE.
REQ-039 reset_n=0 for one cycle during CALC of value 8'h03 -> no rsp_valid, done_cnt=0, next grant goes to requester 0.
REQ-040 done_cnt preloaded near wrap via 65536 responses (or forced) -> 16'hFFFF followed by 16'h0000.
